// File: rtl/vga_text_render.sv
// Text-mode pixel renderer. It turns a stream of pixel positions into character-buffer
// and font-ROM lookups, then into palette colours with blink and cursor effects.
// The pipeline has a fixed 5-cycle latency. It accepts one pixel per clock and never stalls.
//
// Ports:
//   clk_i, rstn_i                pixel clock, async active-low reset
//   x_px_i, y_px_i               current pixel position
//   activevideo_i                display-zone flag
//   hsync_i, vsync_i             active-low syncs from the timing generator
//   cursor_en_i/col_i/row_i      cursor control
//   cbuf_addr_o / cbuf_data_i    character buffer (1-cycle read latency)
//   font_addr_o / font_data_i    font ROM {code, glyph_row} (1-cycle read latency)
//   red_o, green_o, blue_o       pixel colour
//   hsync_o, vsync_o             syncs delayed to align with colour
module vga_text_render #(
  parameter int unsigned COLS    = 160,
  parameter int unsigned ROWS    = 60,
  parameter int unsigned CBUF_AW = 14
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [10:0]        x_px_i,
  input  logic [10:0]        y_px_i,
  input  logic               activevideo_i,
  input  logic               hsync_i,
  input  logic               vsync_i,
  input  logic               cursor_en_i,
  input  logic [7:0]         cursor_col_i,
  input  logic [5:0]         cursor_row_i,
  output logic [CBUF_AW-1:0] cbuf_addr_o,
  input  logic [15:0]        cbuf_data_i,
  output logic [11:0]        font_addr_o,
  input  logic [7:0]         font_data_i,
  output logic [3:0]         red_o,
  output logic [3:0]         green_o,
  output logic [3:0]         blue_o,
  output logic               hsync_o,
  output logic               vsync_o
);

  localparam int unsigned H_PIX = 8 * COLS;
  localparam int unsigned V_PIX = 16 * ROWS;

  // Sideband fields that travel with each pixel
  typedef struct packed {
    logic       vis;
    logic [2:0] xl;
    logic [3:0] yl;
    logic       hs;
    logic       vs;
    logic       cur;
  } side_t;

  localparam side_t SIDE_RST = '{vis: 1'b0, xl: 3'd0, yl: 4'd0, hs: 1'b1, vs: 1'b1, cur: 1'b0};

  side_t s1, s2, s3, s4;

  logic [7:0] s1_col;
  logic [6:0] s1_row;
  logic       s1_cur_en;
  logic [7:0] s1_cur_col;
  logic [5:0] s1_cur_row;

  logic [3:0] fg3, fg4;
  logic [2:0] bg3, bg4;
  logic       blink3, blink4;

  logic       vs_prev;
  logic [5:0] frame_cnt;

  logic               vis_c;
  logic [CBUF_AW-1:0] addr_c;
  logic               pix_c;
  logic               swap_c;
  logic [3:0]         fg_eff_c;
  logic [3:0]         idx_c;
  logic [11:0]        colour_c;

  // Palette: {I,R,G,B} -> 4-bit level per channel
  function automatic logic [3:0] level(input logic on, input logic inten);
    if (on) return inten ? 4'hF : 4'hA;
    else    return inten ? 4'h5 : 4'h0;
  endfunction

  function automatic logic [11:0] palette(input logic [3:0] idx);
    return {level(idx[2], idx[3]), level(idx[1], idx[3]), level(idx[0], idx[3])};
  endfunction

  // Input-stage visibility and buffer address
  always_comb begin
    vis_c  = activevideo_i && (32'(x_px_i) < H_PIX) && (32'(y_px_i) < V_PIX);
    addr_c = '0;
    if (vis_c)
      addr_c = CBUF_AW'(32'(y_px_i[10:4]) * COLS + 32'(x_px_i[10:3]));
  end

  // Stage 1: buffer address, position sideband, cursor sampled with the cell position
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cbuf_addr_o <= '0;
      s1          <= SIDE_RST;
      s1_col      <= '0;
      s1_row      <= '0;
      s1_cur_en   <= 1'b0;
      s1_cur_col  <= '0;
      s1_cur_row  <= '0;
    end else begin
      cbuf_addr_o <= addr_c;
      s1.vis      <= vis_c;
      s1.xl       <= x_px_i[2:0];
      s1.yl       <= y_px_i[3:0];
      s1.hs       <= hsync_i;
      s1.vs       <= vsync_i;
      s1.cur      <= 1'b0;
      s1_col      <= x_px_i[10:3];
      s1_row      <= y_px_i[10:4];
      s1_cur_en   <= cursor_en_i;
      s1_cur_col  <= cursor_col_i;
      s1_cur_row  <= cursor_row_i;
    end
  end

  // Stage 2: resolve whether this cell is the cursor cell
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s2 <= SIDE_RST;
    end else begin
      s2     <= s1;
      s2.cur <= s1_cur_en && (s1_col == s1_cur_col) && (s1_row == {1'b0, s1_cur_row});
    end
  end

  // Stage 3: font address from the cell code, capture attributes
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s3          <= SIDE_RST;
      font_addr_o <= '0;
      fg3         <= '0;
      bg3         <= '0;
      blink3      <= 1'b0;
    end else begin
      s3          <= s2;
      font_addr_o <= {cbuf_data_i[7:0], s2.yl};
      fg3         <= cbuf_data_i[11:8];
      bg3         <= cbuf_data_i[14:12];
      blink3      <= cbuf_data_i[15];
    end
  end

  // Stage 4: wait for the glyph row from the font ROM
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s4     <= SIDE_RST;
      fg4    <= '0;
      bg4    <= '0;
      blink4 <= 1'b0;
    end else begin
      s4     <= s3;
      fg4    <= fg3;
      bg4    <= bg3;
      blink4 <= blink3;
    end
  end

  // Frame counter advances on each vsync falling edge
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      vs_prev   <= 1'b1;
      frame_cnt <= '0;
    end else begin
      vs_prev <= vsync_i;
      if (vs_prev && !vsync_i)
        frame_cnt <= 6'(frame_cnt + 6'd1);
    end
  end

  // Colour selection: blink replaces fg first, then the cursor swaps fg and bg
  always_comb begin
    pix_c    = font_data_i[3'(3'd7 - s4.xl)];
    fg_eff_c = (blink4 && frame_cnt[5]) ? {1'b0, bg4} : fg4;
    swap_c   = s4.cur && (s4.yl >= 4'd14) && frame_cnt[4];
    idx_c    = (pix_c ^ swap_c) ? fg_eff_c : {1'b0, bg4};
    colour_c = 12'h000;
    if (s4.vis)
      colour_c = palette(idx_c);
  end

  // Output stage
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      red_o   <= '0;
      green_o <= '0;
      blue_o  <= '0;
      hsync_o <= 1'b1;
      vsync_o <= 1'b1;
    end else begin
      red_o   <= colour_c[11:8];
      green_o <= colour_c[7:4];
      blue_o  <= colour_c[3:0];
      hsync_o <= s4.hs;
      vsync_o <= s4.vs;
    end
  end

endmodule

// File: tb/tb_vga_text_render.sv
// Directed testbench for vga_text_render. The character buffer and the font ROM are held at
// constant words, so the expected colours and addresses can be worked out by hand.
module tb_vga_text_render;

  logic        clk_i;
  logic        rstn_i;
  logic [10:0] x_px_i, y_px_i;
  logic        activevideo_i, hsync_i, vsync_i;
  logic        cursor_en_i;
  logic [7:0]  cursor_col_i;
  logic [5:0]  cursor_row_i;
  logic [13:0] cbuf_addr_o;
  logic [15:0] cbuf_data_i;
  logic [11:0] font_addr_o;
  logic [7:0]  font_data_i;
  logic [3:0]  red_o, green_o, blue_o;
  logic        hsync_o, vsync_o;

  wire [11:0] rgb = {red_o, green_o, blue_o};

  int checks   = 0;
  int failures = 0;
  int frames   = 0;

  vga_text_render dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .x_px_i(x_px_i), .y_px_i(y_px_i),
    .activevideo_i(activevideo_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .cursor_en_i(cursor_en_i), .cursor_col_i(cursor_col_i), .cursor_row_i(cursor_row_i),
    .cbuf_addr_o(cbuf_addr_o), .cbuf_data_i(cbuf_data_i),
    .font_addr_o(font_addr_o), .font_data_i(font_data_i),
    .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
    .hsync_o(hsync_o), .vsync_o(vsync_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic tick(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic drive(input logic [10:0] x, input logic [10:0] y, input logic av);
    x_px_i = x;
    y_px_i = y;
    activevideo_i = av;
  endtask

  // One pixel for one cycle, then blank; returns at the negedge where that pixel is at the outputs
  task automatic pulse_pixel(input logic [10:0] x, input logic [10:0] y, input logic av);
    drive(x, y, av);
    tick(1);
    drive(11'd0, 11'd0, 1'b0);
    tick(4);
  endtask

  task automatic vsync_pulse();
    vsync_i = 1'b0;
    tick(1);
    vsync_i = 1'b1;
    tick(1);
    frames = (frames + 1) % 64;
  endtask

  task automatic advance_to(input int target);
    int n;
    n = (target - frames + 64) % 64;
    repeat (n) vsync_pulse();
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    drive(11'd8, 11'd16, 1'b1);
    hsync_i = 1'b0;
    vsync_i = 1'b0;
    cursor_en_i = 1'b0;
    cursor_col_i = 8'd0;
    cursor_row_i = 6'd0;
    cbuf_data_i = 16'hFFFF;
    font_data_i = 8'hFF;
    tick(3);
    checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL reset_rgb got=%h exp=000", rgb); end
    checks++; if (hsync_o !== 1'b1) begin failures++; $display("FAIL reset_hsync got=%b exp=1", hsync_o); end
    checks++; if (vsync_o !== 1'b1) begin failures++; $display("FAIL reset_vsync got=%b exp=1", vsync_o); end
    checks++; if (cbuf_addr_o !== 14'd0) begin failures++; $display("FAIL reset_cbuf_addr got=%0d exp=0", cbuf_addr_o); end
    checks++; if (font_addr_o !== 12'h000) begin failures++; $display("FAIL reset_font_addr got=%h exp=000", font_addr_o); end
    hsync_i = 1'b1;
    vsync_i = 1'b1;
    drive(11'd0, 11'd0, 1'b0);
    tick(1);
    rstn_i = 1'b1;
    tick(6);
  endtask

  task automatic test_addr();
    cbuf_data_i = 16'h0F41;
    drive(11'd8, 11'd16, 1'b1);
    tick(1);
    checks++; if (cbuf_addr_o !== 14'd161) begin failures++; $display("FAIL addr_8_16 got=%0d exp=161", cbuf_addr_o); end
    tick(2);
    checks++; if (font_addr_o !== 12'h410) begin failures++; $display("FAIL font_addr_8_16 got=%h exp=410", font_addr_o); end
    drive(11'd1279, 11'd959, 1'b1);
    tick(1);
    checks++; if (cbuf_addr_o !== 14'd9599) begin failures++; $display("FAIL addr_max got=%0d exp=9599", cbuf_addr_o); end
    tick(2);
    checks++; if (font_addr_o !== 12'h41F) begin failures++; $display("FAIL font_addr_max got=%h exp=41f", font_addr_o); end
    drive(11'd17, 11'd33, 1'b1);
    tick(1);
    checks++; if (cbuf_addr_o !== 14'd322) begin failures++; $display("FAIL addr_17_33 got=%0d exp=322", cbuf_addr_o); end
    drive(11'd1280, 11'd0, 1'b1);
    tick(1);
    checks++; if (cbuf_addr_o !== 14'd0) begin failures++; $display("FAIL addr_x_out got=%0d exp=0", cbuf_addr_o); end
    drive(11'd0, 11'd960, 1'b1);
    tick(1);
    checks++; if (cbuf_addr_o !== 14'd0) begin failures++; $display("FAIL addr_y_out got=%0d exp=0", cbuf_addr_o); end
    drive(11'd8, 11'd16, 1'b0);
    tick(1);
    checks++; if (cbuf_addr_o !== 14'd0) begin failures++; $display("FAIL addr_blank got=%0d exp=0", cbuf_addr_o); end
    drive(11'd0, 11'd0, 1'b0);
    tick(6);
  endtask

  task automatic test_latency();
    cbuf_data_i = 16'h2C41;
    font_data_i = 8'h80;
    drive(11'd8, 11'd16, 1'b1);
    tick(1);
    drive(11'd0, 11'd0, 1'b0);
    tick(3);
    checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL latency_n4 got=%h exp=000", rgb); end
    tick(1);
    checks++; if (rgb !== 12'hF55) begin failures++; $display("FAIL latency_n5 got=%h exp=f55", rgb); end
    tick(1);
    checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL latency_n6 got=%h exp=000", rgb); end
  endtask

  task automatic test_colour();
    cbuf_data_i = 16'h0F41;
    font_data_i = 8'h80;
    pulse_pixel(11'd8, 11'd16, 1'b1);
    checks++; if (rgb !== 12'hFFF) begin failures++; $display("FAIL colour_white got=%h exp=fff", rgb); end
    pulse_pixel(11'd9, 11'd16, 1'b1);
    checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL colour_black got=%h exp=000", rgb); end
    cbuf_data_i = 16'h2C41;
    pulse_pixel(11'd9, 11'd16, 1'b1);
    checks++; if (rgb !== 12'h0A0) begin failures++; $display("FAIL colour_bg2 got=%h exp=0a0", rgb); end
    font_data_i = 8'h01;
    pulse_pixel(11'd15, 11'd16, 1'b1);
    checks++; if (rgb !== 12'hF55) begin failures++; $display("FAIL colour_bit0 got=%h exp=f55", rgb); end
    pulse_pixel(11'd14, 11'd16, 1'b1);
    checks++; if (rgb !== 12'h0A0) begin failures++; $display("FAIL colour_bit1 got=%h exp=0a0", rgb); end
    cbuf_data_i = 16'h0941;
    font_data_i = 8'h80;
    pulse_pixel(11'd8, 11'd16, 1'b1);
    checks++; if (rgb !== 12'h55F) begin failures++; $display("FAIL colour_fg9 got=%h exp=55f", rgb); end
    cbuf_data_i = 16'h7741;
    pulse_pixel(11'd9, 11'd16, 1'b1);
    checks++; if (rgb !== 12'hAAA) begin failures++; $display("FAIL colour_bg7 got=%h exp=aaa", rgb); end
  endtask

  task automatic test_invisible();
    cbuf_data_i = 16'h2C41;
    font_data_i = 8'hFF;
    pulse_pixel(11'd8, 11'd16, 1'b0);
    checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL invis_av0 got=%h exp=000", rgb); end
    pulse_pixel(11'd1280, 11'd16, 1'b1);
    checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL invis_x got=%h exp=000", rgb); end
    pulse_pixel(11'd8, 11'd960, 1'b1);
    checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL invis_y got=%h exp=000", rgb); end
    pulse_pixel(11'd1279, 11'd959, 1'b1);
    checks++; if (rgb !== 12'hF55) begin failures++; $display("FAIL visible_corner got=%h exp=f55", rgb); end
  endtask

  task automatic test_sync();
    drive(11'd0, 11'd0, 1'b0);
    hsync_i = 1'b0;
    tick(2);
    hsync_i = 1'b1;
    tick(2);
    checks++; if (hsync_o !== 1'b1) begin failures++; $display("FAIL hsync_n4 got=%b exp=1", hsync_o); end
    tick(1);
    checks++; if (hsync_o !== 1'b0) begin failures++; $display("FAIL hsync_n5 got=%b exp=0", hsync_o); end
    tick(1);
    checks++; if (hsync_o !== 1'b0) begin failures++; $display("FAIL hsync_n6 got=%b exp=0", hsync_o); end
    tick(1);
    checks++; if (hsync_o !== 1'b1) begin failures++; $display("FAIL hsync_n7 got=%b exp=1", hsync_o); end
    vsync_i = 1'b0;
    tick(1);
    vsync_i = 1'b1;
    frames = (frames + 1) % 64;
    tick(3);
    checks++; if (vsync_o !== 1'b1) begin failures++; $display("FAIL vsync_n4 got=%b exp=1", vsync_o); end
    tick(1);
    checks++; if (vsync_o !== 1'b0) begin failures++; $display("FAIL vsync_n5 got=%b exp=0", vsync_o); end
    tick(1);
    checks++; if (vsync_o !== 1'b1) begin failures++; $display("FAIL vsync_n6 got=%b exp=1", vsync_o); end
  endtask

  task automatic test_blink();
    cbuf_data_i = 16'hAC41;
    font_data_i = 8'h80;
    pulse_pixel(11'd8, 11'd16, 1'b1);
    checks++; if (rgb !== 12'hF55) begin failures++; $display("FAIL blink_off got=%h exp=f55", rgb); end
    advance_to(32);
    pulse_pixel(11'd8, 11'd16, 1'b1);
    checks++; if (rgb !== 12'h0A0) begin failures++; $display("FAIL blink_on got=%h exp=0a0", rgb); end
    pulse_pixel(11'd9, 11'd16, 1'b1);
    checks++; if (rgb !== 12'h0A0) begin failures++; $display("FAIL blink_bgpix got=%h exp=0a0", rgb); end
    advance_to(63);
    pulse_pixel(11'd8, 11'd16, 1'b1);
    checks++; if (rgb !== 12'h0A0) begin failures++; $display("FAIL blink_63 got=%h exp=0a0", rgb); end
    advance_to(0);
    pulse_pixel(11'd8, 11'd16, 1'b1);
    checks++; if (rgb !== 12'hF55) begin failures++; $display("FAIL blink_wrap got=%h exp=f55", rgb); end
    cbuf_data_i = 16'h2C41;
    advance_to(32);
    pulse_pixel(11'd8, 11'd16, 1'b1);
    checks++; if (rgb !== 12'hF55) begin failures++; $display("FAIL noblink_cell got=%h exp=f55", rgb); end
  endtask

  task automatic test_cursor();
    cbuf_data_i = 16'h2C41;
    font_data_i = 8'h80;
    cursor_en_i = 1'b1;
    cursor_col_i = 8'd3;
    cursor_row_i = 6'd2;
    advance_to(16);
    pulse_pixel(11'd24, 11'd47, 1'b1);
    checks++; if (rgb !== 12'h0A0) begin failures++; $display("FAIL cursor_fg_swap got=%h exp=0a0", rgb); end
    pulse_pixel(11'd25, 11'd47, 1'b1);
    checks++; if (rgb !== 12'hF55) begin failures++; $display("FAIL cursor_bg_swap got=%h exp=f55", rgb); end
    pulse_pixel(11'd24, 11'd46, 1'b1);
    checks++; if (rgb !== 12'h0A0) begin failures++; $display("FAIL cursor_row14 got=%h exp=0a0", rgb); end
    pulse_pixel(11'd24, 11'd45, 1'b1);
    checks++; if (rgb !== 12'hF55) begin failures++; $display("FAIL cursor_row13 got=%h exp=f55", rgb); end
    pulse_pixel(11'd32, 11'd47, 1'b1);
    checks++; if (rgb !== 12'hF55) begin failures++; $display("FAIL cursor_other_col got=%h exp=f55", rgb); end
    pulse_pixel(11'd24, 11'd63, 1'b1);
    checks++; if (rgb !== 12'hF55) begin failures++; $display("FAIL cursor_other_row got=%h exp=f55", rgb); end
    cursor_en_i = 1'b0;
    pulse_pixel(11'd24, 11'd47, 1'b1);
    checks++; if (rgb !== 12'hF55) begin failures++; $display("FAIL cursor_disabled got=%h exp=f55", rgb); end
    cursor_en_i = 1'b1;
    advance_to(32);
    pulse_pixel(11'd24, 11'd47, 1'b1);
    checks++; if (rgb !== 12'hF55) begin failures++; $display("FAIL cursor_phase_off got=%h exp=f55", rgb); end
    cursor_en_i = 1'b0;
  endtask

  task automatic test_mid_reset();
    cbuf_data_i = 16'h2C41;
    font_data_i = 8'h80;
    drive(11'd8, 11'd16, 1'b1);
    hsync_i = 1'b0;
    tick(6);
    checks++; if (rgb !== 12'hF55) begin failures++; $display("FAIL prereset_rgb got=%h exp=f55", rgb); end
    checks++; if (hsync_o !== 1'b0) begin failures++; $display("FAIL prereset_hsync got=%b exp=0", hsync_o); end
    #2;
    rstn_i = 1'b0;
    #1;
    checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL midreset_rgb got=%h exp=000", rgb); end
    checks++; if (hsync_o !== 1'b1 || vsync_o !== 1'b1) begin failures++; $display("FAIL midreset_sync got=%b%b exp=11", hsync_o, vsync_o); end
    checks++; if (cbuf_addr_o !== 14'd0) begin failures++; $display("FAIL midreset_addr got=%0d exp=0", cbuf_addr_o); end
    hsync_i = 1'b1;
    drive(11'd0, 11'd0, 1'b0);
    tick(2);
    rstn_i = 1'b1;
    drive(11'd8, 11'd16, 1'b1);
    tick(1);
    drive(11'd0, 11'd0, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL postreset_n%0d got=%h exp=000", k, rgb); end
      if (k < 4) tick(1);
    end
    tick(1);
    checks++; if (rgb !== 12'hF55) begin failures++; $display("FAIL postreset_n5 got=%h exp=f55", rgb); end
    tick(1);
    checks++; if (rgb !== 12'h000) begin failures++; $display("FAIL postreset_n6 got=%h exp=000", rgb); end
  endtask

  initial begin
    test_reset();
    test_addr();
    test_latency();
    test_colour();
    test_invisible();
    test_sync();
    test_blink();
    test_cursor();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_text_render.md
VGA_TEXT_RENDER -- requirements
Module: vga_text_render

Interface
REQ-001 Parameter COLS, default 160: text columns, 8-px-wide cells.
REQ-002 Parameter ROWS, default 60: text rows, 16-line-high cells.
REQ-003 Parameter CBUF_AW, default 14: character-buffer address width.
REQ-004 clk_i  input  1  pixel clock, 102.1 MHz.
REQ-005 rstn_i  input  1  reset, asynchronous, active-low.
REQ-006 x_px_i, y_px_i  input  11 each  current pixel position.
REQ-007 activevideo_i  input  1  high in the display zone.
REQ-008 hsync_i, vsync_i  input  1 each  active-low syncs from the timing generator.
REQ-009 cursor_en_i  input  1  cursor enable.
REQ-010 cursor_col_i  input  8  cursor column.
REQ-011 cursor_row_i  input  6  cursor row.
REQ-012 cbuf_addr_o  output  CBUF_AW  character-buffer read address.
REQ-013 cbuf_data_i  input  16  cell word: [7:0] code, [11:8] fg index, [14:12] bg index, [15] blink.
REQ-014 font_addr_o  output  12  font ROM address {code, glyph_row[3:0]}.
REQ-015 font_data_i  input  8  glyph row; bit 7 is the leftmost pixel.
REQ-016 red_o, green_o, blue_o  output  4 each  pixel colour.
REQ-017 hsync_o, vsync_o  output  1 each  syncs delayed to align with colour.

Function
REQ-018 External RAM/ROM: read data SHALL be valid exactly one clock after the address is registered.
REQ-019 Cycle N, input sampling: the block SHALL treat a pixel as visible only when activevideo_i=1, x_px_i<8*COLS and y_px_i<16*ROWS.
REQ-020 Edge ending N: cbuf_addr_o SHALL be registered as (y_px_i>>4)*COLS + (x_px_i>>3) when visible, else 0.
REQ-021 Max address: COLS*ROWS-1 (9599 at default); no wrap.
REQ-022 Edge ending N+1: the block SHALL register the visible flag, x[2:0], y[3:0], cell column/row and syncs as a sideband pipe, one stage per edge.
REQ-023 Edge ending N+2: font_addr_o SHALL be registered as {cbuf_data_i[7:0], y[3:0]}, and the attribute bits SHALL be registered alongside it.
REQ-024 Edge ending N+4: red/green/blue/hsync/vsync outputs SHALL be registered; pixel N appears at the outputs in cycle N+5, a fixed 5-cycle latency.
REQ-025 Pixel bit: font_data_i[7 - x[2:0]]; 1 selects fg, 0 selects bg.
REQ-026 Palette, index {I,R,G,B}: channel = bit ? (I ? 4'hF : 4'hA) : (I ? 4'h5 : 4'h0).
REQ-027 The bg index is 3 bits and SHALL be palette-mapped with I=0.
REQ-028 Frame counter: 6-bit, increments on each vsync_i 1->0 transition and wraps 63->0.
REQ-029 Blink: when cell bit 15=1 and counter[5]=1, fg SHALL be replaced by bg.
REQ-030 Cursor: when cursor_en_i=1, the cell matches cursor_col_i/cursor_row_i, glyph row ≥14 and counter[4]=1, the pixel colour SHALL be inverted (fg and bg swapped after blink).
REQ-031 Cursor inputs SHALL be sampled in the same stage as the cell position, and changes take effect on the next pixel.
REQ-032 Non-visible pixel: the colour outputs SHALL be 0 regardless of RAM/ROM data.
REQ-033 hsync_o/vsync_o SHALL equal hsync_i/vsync_i delayed exactly 5 cycles, unmodified.
REQ-034 The pipeline SHALL have no stall or handshake, accepting one pixel per clock continuously.

Reset
REQ-035 While rstn_i=0, all pipeline registers SHALL clear asynchronously.
REQ-036 Reset values: RGB=0, hsync_o=vsync_o=1, cbuf_addr_o=0, font_addr_o=0, frame counter=0, visible flags=0.
REQ-037 After release, the first valid pixel SHALL appear 5 cycles after the first visible input.
REQ-038 The outputs SHALL stay black/inactive-sync until the pipeline refills.
REQ-039 Reset mid-frame: on release, the block SHALL resume with no residual pixels from before reset.

Verification
REQ-040 Input (x=8,y=16) visible -> cbuf_addr_o=161 next cycle; with cbuf_data_i=16'h0F41, font_addr_o=12'h410 two cycles later.
REQ-041 font_data_i=8'h80, fg=F, bg=0, x[2:0]=0 -> RGB=F,F,F at N+5; x[2:0]=1 -> RGB=0,0,0.
REQ-042 activevideo_i=0 with arbitrary RAM/ROM data -> RGB=0; hsync_i pulse -> identical pulse on hsync_o 5 cycles later.
REQ-043 Blink cell, 32 vsync falling edges -> fg pixels become bg colour; after 64 edges they return to fg (counter wrap).
REQ-044 Cursor at (3,2), glyph row 15, counter[4]=1 -> fg/bg swapped; glyph row 13 -> not swapped.
REQ-045 Assert rstn_i mid-line -> outputs immediately RGB=0, syncs=1; after release, the first visible pixel appears at exactly N+5.
